pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Registered program-counter unit, successor to the combinational gen_branch_signal + sequencer pair.
- Owns the PC register and evaluates branch conditions from the execute stage.
- Computes the fall-through address itself (pc + INSN_BYTES).
- Holds a redirect raised during a stall until the stall drops.
- Traps on misaligned targets.
- Sits between the execute stage and instruction fetch.

Parameters:
XLEN, 32, datapath/address width
RESET_VECTOR, 32'h0000_0000, PC value after reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on misaligned-target trap
INSN_BYTES, 4, fall-through increment
ALIGN_BITS, 2, low target bits that must be zero

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
ex_valid  in  1  info_branch/reg1/reg2/target describe a resolved instruction this cycle
info_branch  in  4  branch code from shared defines: Beq, Bne, Blt, Bge, Bltu, Bgeu, BJAL, BJALR, NOTBRANCH
reg1  in  XLEN  rs1 operand
reg2  in  XLEN  rs2 operand
target  in  XLEN  branch/jump target from the ALU
stall  in  1  fetch cannot accept a new PC; hold pc
trap_ack  in  1  trap handler accepted the trap
pc  out  XLEN  current fetch address
pc_valid  out  1  pc is a valid fetch address
flush  out  1  one-cycle pulse: younger in-flight instructions are invalid
branch_taken  out  1  registered, one-cycle pulse per accepted taken redirect
misalign_trap  out  1  level; high in TRAP state
trap_addr  out  XLEN  offending target, captured on trap entry

Behaviour:
- Reset (async assert, any state): pc=RESET_VECTOR, pc_valid=0, flush=0, branch_taken=0, misalign_trap=0, trap_addr=0, pending cleared, state=BOOT.
- Taken condition, combinational, full XLEN compare:
  - Beq: reg1==reg2. Bne: reg1!=reg2.
  - Blt/Bge: signed compare. Bltu/Bgeu: unsigned compare.
  - BJAL, BJALR: always taken. NOTBRANCH and undefined codes: never taken.
- Effective target: BJALR uses target with bit0 cleared; all other codes use target unchanged.
- Misaligned: taken and effective target[ALIGN_BITS-1:0] != 0.
- FSM states BOOT, RUN, TRAP:
  - BOOT: exactly one cycle after reset release. Then RUN with pc_valid=1 and pc=RESET_VECTOR.
  - RUN, stall=0, no pending redirect:
    - ex_valid and taken and aligned: pc <= effective target; flush=1 and branch_taken=1 next cycle.
    - Otherwise: pc <= pc+INSN_BYTES, wrapping modulo 2^XLEN.
  - RUN, stall=1:
    - pc held.
    - ex_valid and taken and aligned with no pending redirect: target latched into pending register; flush and branch_taken pulse next cycle.
    - ex_valid while pending is set: ignored, since the instruction is already flushed.
  - RUN, stall falls with pending set: pc <= pending target; pending cleared; no second flush.
  - Misaligned taken in RUN (stall irrelevant, pending not set): state=TRAP; trap_addr <= effective target; misalign_trap=1; pc_valid=0; pc <= TRAP_VECTOR; flush pulses once.
  - TRAP: ex_valid and stall ignored. When trap_ack=1: RUN, pc_valid=1, pc stays TRAP_VECTOR, misalign_trap=0.
- Latency: ex_valid edge to new pc is 1 cycle. flush and branch_taken are registered and align with the pc update.
- Simultaneous pending release and a new ex_valid: the new instruction is ignored; the pending target wins.

Decomposition:
- Shared define file (existing 99_define.v) keeps the branch codes.
- Add FSM state encodings PCS_BOOT, PCS_RUN, PCS_TRAP to the same file.
- Sub-module branch_cond (parametrised-XLEN condition evaluator) replaces gen_branch_signal.
- Top level holds the FSM, PC, pending register and trap capture.

Test Plan:
1. Reset, RESET_VECTOR=0x1000, stall=0 → BOOT 1 cycle with pc_valid=0; then pc=0x1000, 0x1004, 0x1008 on successive cycles.
2. Bne, reg1=0xFFABCD5A, reg2=0x123ABDEA, target=0x2000 → next cycle pc=0x2000, flush=1 and branch_taken=1 for exactly one cycle. Bgeu with the same operands also taken. Blt with the same operands is taken (signed compare); Bltu and Beq are not taken, so pc increments by 4.
3. stall=1 with BJAL target=0x3000, then a second ex_valid BJAL target=0x4000 while stalled; release stall after 3 cycles → pc held, then pc=0x3000; single flush pulse; 0x4000 never appears.
4. BJALR target=0x00005003 → effective target 0x5002, misaligned → misalign_trap=1, trap_addr=0x5002, pc=TRAP_VECTOR, pc_valid=0; trap_ack → pc_valid=1 at 0x100.
5. pc=0xFFFFFFFC with no branch → next pc=0x00000000 (wrap). XLEN=64 instance: Blt with reg1=-1, reg2=1 → taken.
6. Assert rst mid-cycle while a redirect is pending → outputs return to reset values immediately; after release, pc=RESET_VECTOR and no pending redirect is applied.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: branch codes and FSM states.
package pc_sequencer_pkg;

  typedef enum logic [3:0] {
    Beq       = 4'd0,
    Bne       = 4'd1,
    Blt       = 4'd4,
    Bge       = 4'd5,
    Bltu      = 4'd6,
    Bgeu      = 4'd7,
    BJAL      = 4'd8,
    BJALR     = 4'd9,
    NOTBRANCH = 4'd15
  } branch_e;

  typedef enum logic [1:0] {
    PCS_BOOT = 2'd0,
    PCS_RUN  = 2'd1,
    PCS_TRAP = 2'd2
  } pcs_state_e;

  localparam int unsigned BRANCH_W = 4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Execute-stage / fetch-side signal bundle for the PC sequencer.
interface pc_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            ex_valid;
    logic [3:0]      info_branch;
    logic [XLEN-1:0] reg1;
    logic [XLEN-1:0] reg2;
    logic [XLEN-1:0] target;
    logic            stall;
    logic            trap_ack;
    logic [XLEN-1:0] pc;
    logic            pc_valid;
    logic            flush;
    logic            branch_taken;
    logic            misalign_trap;
    logic [XLEN-1:0] trap_addr;

    modport master (
        output ex_valid, info_branch, reg1, reg2, target, stall, trap_ack,
        input  pc, pc_valid, flush, branch_taken, misalign_trap, trap_addr
    );

    modport slave (
        input  ex_valid, info_branch, reg1, reg2, target, stall, trap_ack,
        output pc, pc_valid, flush, branch_taken, misalign_trap, trap_addr
    );
endinterface

// File: rtl/pc_sequencer_branch_cond.sv
// Combinational branch-condition evaluator over full-width operands.
module branch_cond
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [3:0]      info_branch,
    input  logic [XLEN-1:0] reg1,
    input  logic [XLEN-1:0] reg2,
    output logic            taken
);

    always_comb begin
        taken = 1'b0;
        case (info_branch)
            Beq:     taken = (reg1 == reg2);
            Bne:     taken = (reg1 != reg2);
            Blt:     taken = ($signed(reg1) <  $signed(reg2));
            Bge:     taken = ($signed(reg1) >= $signed(reg2));
            Bltu:    taken = (reg1 <  reg2);
            Bgeu:    taken = (reg1 >= reg2);
            BJAL:    taken = 1'b1;
            BJALR:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter: branch resolution, stall-held redirects and misaligned-target trap.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h0000_0100,
    parameter int unsigned     INSN_BYTES   = 4,
    parameter int unsigned     ALIGN_BITS   = 2
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);

    pcs_state_e      state;
    logic            pend_valid;
    logic [XLEN-1:0] pend_target;

    logic            taken;
    logic [XLEN-1:0] eff_target;
    logic            misaligned;
    logic            redirect;

    branch_cond #(
        .XLEN (XLEN)
    ) u_branch_cond (
        .info_branch (bus.info_branch),
        .reg1        (bus.reg1),
        .reg2        (bus.reg2),
        .taken       (taken)
    );

    always_comb begin
        eff_target = bus.target;
        if (bus.info_branch == BJALR) eff_target = {bus.target[XLEN-1:1], 1'b0};
        misaligned = taken && (|eff_target[ALIGN_BITS-1:0]);
        redirect   = bus.ex_valid && taken;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= PCS_BOOT;
            bus.pc            <= RESET_VECTOR;
            bus.pc_valid      <= 1'b0;
            bus.flush         <= 1'b0;
            bus.branch_taken  <= 1'b0;
            bus.misalign_trap <= 1'b0;
            bus.trap_addr     <= '0;
            pend_valid        <= 1'b0;
            pend_target       <= '0;
        end else begin
            bus.flush        <= 1'b0;
            bus.branch_taken <= 1'b0;
            case (state)
                PCS_BOOT: begin
                    state        <= PCS_RUN;
                    bus.pc_valid <= 1'b1;
                    bus.pc       <= RESET_VECTOR;
                end
                PCS_RUN: begin
                    // A held redirect owns the slot: anything arriving meanwhile is already flushed.
                    if (pend_valid) begin
                        if (!bus.stall) begin
                            bus.pc     <= pend_target;
                            pend_valid <= 1'b0;
                        end
                    end else if (redirect && misaligned) begin
                        state             <= PCS_TRAP;
                        bus.trap_addr     <= eff_target;
                        bus.misalign_trap <= 1'b1;
                        bus.pc_valid      <= 1'b0;
                        bus.pc            <= TRAP_VECTOR;
                        bus.flush         <= 1'b1;
                    end else if (redirect) begin
                        bus.flush        <= 1'b1;
                        bus.branch_taken <= 1'b1;
                        if (bus.stall) begin
                            pend_valid  <= 1'b1;
                            pend_target <= eff_target;
                        end else begin
                            bus.pc <= eff_target;
                        end
                    end else if (!bus.stall) begin
                        bus.pc <= bus.pc + XLEN'(INSN_BYTES);
                    end
                end
                PCS_TRAP: begin
                    if (bus.trap_ack) begin
                        state             <= PCS_RUN;
                        bus.pc_valid      <= 1'b1;
                        bus.misalign_trap <= 1'b0;
                    end
                end
                default: begin
                    state <= PCS_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues expected outputs, monitors compare after each edge.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    typedef struct packed {
        logic [63:0] pc;
        logic        pc_valid;
        logic        flush;
        logic        bt;
        logic        trap;
        logic [63:0] ta;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_sequencer_if #(.XLEN(32)) bus32 ();
    pc_sequencer_if #(.XLEN(64)) bus64 ();

    pc_sequencer #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_1000),
        .TRAP_VECTOR  (32'h0000_0100),
        .INSN_BYTES   (4),
        .ALIGN_BITS   (2)
    ) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32.slave)
    );

    pc_sequencer #(
        .XLEN         (64),
        .RESET_VECTOR (64'h0),
        .TRAP_VECTOR  (64'h100),
        .INSN_BYTES   (4),
        .ALIGN_BITS   (2)
    ) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (bus64.slave)
    );

    exp_t q32[$];
    exp_t q64[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic exp_t mk(logic [63:0] pc, logic v, logic f, logic b, logic t, logic [63:0] ta);
        exp_t e;
        e.pc = pc; e.pc_valid = v; e.flush = f; e.bt = b; e.trap = t; e.ta = ta;
        return e;
    endfunction

    // Monitors: sample shortly after every clock edge or reset assertion.
    always @(posedge clk or posedge rst) begin
        exp_t e, g;
        #1;
        if (q32.size() > 0) begin
            e = q32.pop_front();
            g = mk({32'h0, bus32.pc}, bus32.pc_valid, bus32.flush, bus32.branch_taken,
                   bus32.misalign_trap, {32'h0, bus32.trap_addr});
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL dut32 @%0t: got pc=%h v=%b f=%b bt=%b tr=%b ta=%h, want pc=%h v=%b f=%b bt=%b tr=%b ta=%h",
                         $time, g.pc[31:0], g.pc_valid, g.flush, g.bt, g.trap, g.ta[31:0],
                         e.pc[31:0], e.pc_valid, e.flush, e.bt, e.trap, e.ta[31:0]);
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        exp_t e, g;
        #1;
        if (q64.size() > 0) begin
            e = q64.pop_front();
            g = mk(bus64.pc, bus64.pc_valid, bus64.flush, bus64.branch_taken,
                   bus64.misalign_trap, bus64.trap_addr);
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL dut64 @%0t: got pc=%h v=%b f=%b bt=%b tr=%b, want pc=%h v=%b f=%b bt=%b tr=%b",
                         $time, g.pc, g.pc_valid, g.flush, g.bt, g.trap,
                         e.pc, e.pc_valid, e.flush, e.bt, e.trap);
            end
        end
    end

    task automatic drv(input logic ev, input logic [3:0] code, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] tgt, input logic stl);
        bus32.ex_valid    = ev;
        bus32.info_branch = code;
        bus32.reg1        = r1;
        bus32.reg2        = r2;
        bus32.target      = tgt;
        bus32.stall       = stl;
    endtask

    task automatic drv64(input logic ev, input logic [3:0] code, input logic [63:0] r1,
                         input logic [63:0] r2, input logic [63:0] tgt);
        bus64.ex_valid    = ev;
        bus64.info_branch = code;
        bus64.reg1        = r1;
        bus64.reg2        = r2;
        bus64.target      = tgt;
    endtask

    task automatic cyc(input exp_t e);
        q32.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    localparam logic [31:0] OPA = 32'hFFAB_CD5A;
    localparam logic [31:0] OPB = 32'h123A_BDEA;

    initial begin
        rst = 1'b1;
        drv(1'b0, NOTBRANCH, '0, '0, '0, 1'b0);
        bus32.trap_ack = 1'b0;
        drv64(1'b0, NOTBRANCH, '0, '0, '0);
        bus64.stall    = 1'b0;
        bus64.trap_ack = 1'b0;
        @(negedge clk);

        // Reset, boot, sequential fetch
        cyc(mk(32'h1000, 0, 0, 0, 0, 0));
        rst = 1'b0;
        cyc(mk(32'h1000, 1, 0, 0, 0, 0));
        cyc(mk(32'h1004, 1, 0, 0, 0, 0));
        cyc(mk(32'h1008, 1, 0, 0, 0, 0));

        // Branch conditions
        drv(1, Bne, OPA, OPB, 32'h2000, 0);       cyc(mk(32'h2000, 1, 1, 1, 0, 0));
        drv(0, NOTBRANCH, 0, 0, 0, 0);            cyc(mk(32'h2004, 1, 0, 0, 0, 0));
        drv(1, Bgeu, OPA, OPB, 32'h2100, 0);      cyc(mk(32'h2100, 1, 1, 1, 0, 0));
        drv(0, NOTBRANCH, 0, 0, 0, 0);            cyc(mk(32'h2104, 1, 0, 0, 0, 0));
        drv(1, Blt, OPA, OPB, 32'h2200, 0);       cyc(mk(32'h2200, 1, 1, 1, 0, 0));
        drv(1, Bltu, OPA, OPB, 32'h2300, 0);      cyc(mk(32'h2204, 1, 0, 0, 0, 0));
        drv(1, Beq, OPA, OPB, 32'h2400, 0);       cyc(mk(32'h2208, 1, 0, 0, 0, 0));
        drv(1, Bge, OPA, OPB, 32'h2500, 0);       cyc(mk(32'h220C, 1, 0, 0, 0, 0));
        drv(1, NOTBRANCH, OPA, OPA, 32'h2600, 0); cyc(mk(32'h2210, 1, 0, 0, 0, 0));
        drv(1, 4'd3, OPA, OPB, 32'h2700, 0);      cyc(mk(32'h2214, 1, 0, 0, 0, 0));

        // Redirect during stall, second redirect ignored
        drv(1, BJAL, 0, 0, 32'h3000, 1);          cyc(mk(32'h2214, 1, 1, 1, 0, 0));
        drv(1, BJAL, 0, 0, 32'h4000, 1);          cyc(mk(32'h2214, 1, 0, 0, 0, 0));
        drv(0, NOTBRANCH, 0, 0, 0, 1);            cyc(mk(32'h2214, 1, 0, 0, 0, 0));
        drv(0, NOTBRANCH, 0, 0, 0, 0);            cyc(mk(32'h3000, 1, 0, 0, 0, 0));
        cyc(mk(32'h3004, 1, 0, 0, 0, 0));
        drv(1, BJAL, 0, 0, 32'h3100, 1);          cyc(mk(32'h3004, 1, 1, 1, 0, 0));
        drv(1, BJAL, 0, 0, 32'h3200, 0);          cyc(mk(32'h3100, 1, 0, 0, 0, 0));
        drv(0, NOTBRANCH, 0, 0, 0, 0);            cyc(mk(32'h3104, 1, 0, 0, 0, 0));

        // Misaligned trap via BJALR, inputs ignored in TRAP, ack
        drv(1, BJALR, 0, 0, 32'h5003, 0);         cyc(mk(32'h0100, 0, 1, 0, 1, 32'h5002));
        drv(1, BJAL, 0, 0, 32'h6000, 1);          cyc(mk(32'h0100, 0, 0, 0, 1, 32'h5002));
        drv(0, NOTBRANCH, 0, 0, 0, 0);
        bus32.trap_ack = 1'b1;                    cyc(mk(32'h0100, 1, 0, 0, 0, 32'h5002));
        bus32.trap_ack = 1'b0;                    cyc(mk(32'h0104, 1, 0, 0, 0, 32'h5002));
        drv(1, Beq, 5, 5, 32'h7001, 1);           cyc(mk(32'h0100, 0, 1, 0, 1, 32'h7001));
        drv(0, NOTBRANCH, 0, 0, 0, 0);
        bus32.trap_ack = 1'b1;                    cyc(mk(32'h0100, 1, 0, 0, 0, 32'h7001));
        bus32.trap_ack = 1'b0;                    cyc(mk(32'h0104, 1, 0, 0, 0, 32'h7001));
        drv(1, Bne, 5, 5, 32'h7003, 0);           cyc(mk(32'h0108, 1, 0, 0, 0, 32'h7001));

        // PC wrap; 64-bit instance compares in parallel
        drv(1, BJAL, 0, 0, 32'hFFFF_FFF8, 0);
        drv64(1, Blt, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h9000);
        q64.push_back(mk(64'h9000, 1, 1, 1, 0, 0));
        cyc(mk(32'hFFFF_FFF8, 1, 1, 1, 0, 32'h7001));
        drv(0, NOTBRANCH, 0, 0, 0, 0);
        drv64(1, Bltu, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'hA000);
        q64.push_back(mk(64'h9004, 1, 0, 0, 0, 0));
        cyc(mk(32'hFFFF_FFFC, 1, 0, 0, 0, 32'h7001));
        drv64(1, Beq, 64'h1_0000_0000, 64'h0, 64'hB000);
        q64.push_back(mk(64'h9008, 1, 0, 0, 0, 0));
        cyc(mk(32'h0000_0000, 1, 0, 0, 0, 32'h7001));
        drv64(0, NOTBRANCH, 0, 0, 0);
        cyc(mk(32'h0000_0004, 1, 0, 0, 0, 32'h7001));

        // Mid-cycle reset with a pending redirect
        drv(1, BJAL, 0, 0, 32'h8000, 1);          cyc(mk(32'h0004, 1, 1, 1, 0, 32'h7001));
        drv(0, NOTBRANCH, 0, 0, 0, 0);
        q32.push_back(mk(32'h1000, 0, 0, 0, 0, 0));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc(mk(32'h1000, 0, 0, 0, 0, 0));
        rst = 1'b0;
        cyc(mk(32'h1000, 1, 0, 0, 0, 0));
        cyc(mk(32'h1004, 1, 0, 0, 0, 0));
        cyc(mk(32'h1008, 1, 0, 0, 0, 0));

        repeat (3) @(negedge clk);
        n_checks++;
        if (q32.size() != 0 || q64.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d/%0d unchecked entries, want 0/0", q32.size(), q64.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
